ramd_stream_reader: RTL and testbench

Read-side initiator for the single-port data RAM (`RamD`): on a start command it walks a contiguous word range of the RAM, issuing one read address per cycle and absorbing the RAM's one-cycle registered read latency. Each word is presented downstream on a valid/ready stream with a last-beat flag. It sits between the data RAM and the consumer logic, for example the phrase display or transmit path, and never writes the RAM.

---
 rtl/ramd_stream_reader.sv | 208 ++++++++++++++++++++
 tb/tb_ramd_stream_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ramd_stream_reader.sv
// ramd_stream_reader: walks a contiguous word range of the data RAM and presents each word on a valid/ready stream.
// Build option RAMD_READER_WRAP_EN: addresses wrap at DEPTH and out-of-range commands are no longer rejected.

module ramd_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 328
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

`ifdef RAMD_READER_WRAP_EN
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        if (addr == ADDR_LAST) begin
            next_addr = ADDR_ZERO;
        end else begin
            next_addr = addr + ADDR_ONE;
        end
    endfunction
`else
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        next_addr = addr + ADDR_ONE;
    endfunction
`endif

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_remain;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_beat;
    logic [ADDR_W-1:0] r_ram_address;
    logic [1:0]        r_pipe_v;
    logic [DATA_W-1:0] r_fifo [4];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [2:0]        w_inflight;
    logic              w_room;
    logic              w_range_bad;
    logic              w_accept;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_nempty;
    logic              w_last;

`ifdef RAMD_READER_WRAP_EN
    assign w_range_bad = 1'b0;
`else
    logic [ADDR_W:0] w_end;
    // Extra bit keeps base+length from overflowing before the comparison.
    assign w_end       = {1'b0, base_addr} + {1'b0, length};
    assign w_range_bad = (w_end > (ADDR_W+1)'(DEPTH));
`endif

    assign w_inflight    = {2'b00, r_pipe_v[0]} + {2'b00, r_pipe_v[1]};
    assign w_room        = ((r_count + w_inflight) < 3'd4);
    assign w_accept      = (r_state == S_IDLE) && start && (length != ADDR_ZERO) && !w_range_bad;
    assign w_issue       = (r_state == S_READ) && w_room;
    assign w_push        = r_pipe_v[1];
    assign w_fifo_nempty = (r_count != 3'd0);
    assign w_pop         = w_fifo_nempty && out_ready;
    assign w_last        = w_fifo_nempty && (r_beat == (r_len - ADDR_ONE));

    // Address issue: the accepting edge already issues the base address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_address <= ADDR_ZERO;
            r_ptr         <= ADDR_ZERO;
            r_remain      <= ADDR_ZERO;
            r_pipe_v      <= 2'b00;
        end else begin
            r_pipe_v <= {r_pipe_v[0], (w_accept | w_issue)};
            if (w_accept) begin
                r_ram_address <= base_addr;
                r_ptr         <= next_addr(base_addr);
                r_remain      <= length - ADDR_ONE;
            end else if (w_issue) begin
                r_ram_address <= r_ptr;
                r_ptr         <= next_addr(r_ptr);
                r_remain      <= r_remain - ADDR_ONE;
            end
        end
    end

    // Four-entry output FIFO fed by the second read-pipeline stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= {DATA_W{1'b0}};
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_q;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Transfer sequencing, beat counting and status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_len   <= ADDR_ZERO;
            r_beat  <= ADDR_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_pop) begin
                r_beat <= r_beat + ADDR_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == ADDR_ZERO) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_range_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= (length == ADDR_ONE) ? S_DRAIN : S_READ;
                            r_busy  <= 1'b1;
                            r_len   <= length;
                            r_beat  <= ADDR_ZERO;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue && (r_remain == ADDR_ONE)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
`ifdef RAMD_READER_WRAP_EN
    assign err         = 1'b0;
`else
    assign err         = r_err;
`endif
    assign ram_address = r_ram_address;
    assign ram_wren    = 1'b0;
    assign ram_data    = {DATA_W{1'b0}};
    assign out_valid   = w_fifo_nempty;
    assign out_data    = r_fifo[r_rd_ptr];
    assign out_last    = w_last;

endmodule

// File: tb/tb_ramd_stream_reader.sv
// Testbench for ramd_stream_reader: behavioural RAM plus a queue-based model of the expected word stream.
module tb_ramd_stream_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 328;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic [DATA_W-1:0] mem [DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ramd_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .err(err),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    // Registered-read RAM: data appears one cycle after the address is sampled.
    always @(posedge clock) begin
        ram_q <= (ram_address < DEPTH) ? mem[ram_address] : '0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic do_xfer(input int base, input int len, input int mode, input bit inject);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] prev_data;
        bit prev_stall;
        bit fin;
        int cyc;
        int accepted;
        int last_pop;
        int idx;
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
        @(negedge clock);
        start = 1'b1; base_addr = base; length = len; out_ready = (mode == 0);
        @(negedge clock);
        start = 1'b0;
        check_eq("issue_base", ram_address, base);
        check_eq("no_early_done", done, 0);
        cyc = 0; accepted = 0; last_pop = -1; fin = 0; prev_stall = 0; prev_data = '0;
        while (!fin && cyc < 300) begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, prev_data);
            end
            if (done) begin
                check_eq("done_all_beats", exp_q.size(), 0);
                check_eq("done_timing", cyc, last_pop + 1);
                check_eq("done_busy", busy, 0);
                fin = 1;
            end else begin
                check_eq("busy", busy, 1);
                idx = (int'(ram_address) - base + DEPTH) % DEPTH;
                check_eq("ahead_le4", (idx - accepted) <= 3, 1);
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: out_ready = $urandom_range(0, 1);
                endcase
                start = inject && (cyc == 2);
                if (inject && cyc == 2) begin
                    base_addr = 100; length = 3;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", out_valid, 0);
                    end else begin
                        if (mode == 0) check_eq("throughput", cyc, 2 + accepted);
                        check_eq("data", out_data, exp_q[0]);
                        check_eq("last", out_last, exp_q.size() == 1);
                        void'(exp_q.pop_front());
                        accepted++;
                        last_pop = cyc;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
            if (!fin) begin
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check_eq("done_timeout", done, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pops;
        int guard;
        logic [ADDR_W-1:0] ra;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        repeat (2) @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_addr", ram_address, 0);
        check_eq("rst_wren", ram_wren, 0);
        check_eq("rst_wdata", ram_data, 0);
        check_eq("rst_odata", out_data, 0);
        reset_n = 1'b1;

        do_xfer(0, 4, 0, 0);
        do_xfer(10, 6, 1, 1);

`ifdef RAMD_READER_WRAP_EN
        do_xfer(327, 2, 0, 0);
`else
        @(negedge clock);
        ra = ram_address;
        start = 1'b1; base_addr = 327; length = 2;
        @(negedge clock);
        start = 1'b0;
        check_eq("err_pulse", err, 1);
        check_eq("err_busy", busy, 0);
        check_eq("err_addr", ram_address, ra);
        @(negedge clock);
        check_eq("err_clear", err, 0);
        check_eq("err_busy2", busy, 0);
        check_eq("err_addr2", ram_address, ra);
        check_eq("err_valid", out_valid, 0);
`endif

        @(negedge clock);
        start = 1'b1; base_addr = 20; length = 0;
        @(negedge clock);
        start = 1'b0;
        check_eq("len0_done", done, 1);
        check_eq("len0_valid", out_valid, 0);
        check_eq("len0_busy", busy, 0);
        @(negedge clock);
        check_eq("len0_done_clr", done, 0);
        check_eq("len0_valid2", out_valid, 0);

        do_xfer(DEPTH - 3, 3, 0, 0);

        for (int t = 0; t < 8; t++) begin
            int l;
            int b;
            l = $urandom_range(1, 20);
`ifdef RAMD_READER_WRAP_EN
            b = $urandom_range(0, DEPTH - 1);
`else
            b = $urandom_range(0, DEPTH - l);
`endif
            do_xfer(b, l, 2, 0);
        end

        @(negedge clock);
        start = 1'b1; base_addr = 0; length = 8; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pops = 0; guard = 0;
        while (pops < 3 && guard < 50) begin
            if (out_valid && out_ready) pops++;
            @(negedge clock);
            guard++;
        end
        check_eq("mid_beats", pops, 3);
        reset_n = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        check_eq("mid_err", err, 0);
        check_eq("mid_valid", out_valid, 0);
        check_eq("mid_last", out_last, 0);
        check_eq("mid_addr", ram_address, 0);
        check_eq("mid_odata", out_data, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_valid", out_valid, 0);
        end
        do_xfer(5, 1, 0, 0);
        check_eq("final_wren", ram_wren, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
